// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel strobe, frame-memory data/address and VGA pin bundle.
// test_en exists only when VGA_TESTPATTERN_EN is defined.
interface vga_timing_gen_if #(parameter int AW = 10);
  logic          pix_en;
`ifdef VGA_TESTPATTERN_EN
  logic          test_en;
`endif
  logic [23:0]   vga_data;
  logic [AW-1:0] h_addr;
  logic [AW-1:0] v_addr;
  logic          hsync;
  logic          vsync;
  logic          valid;
  logic [7:0]    vga_r;
  logic [7:0]    vga_g;
  logic [7:0]    vga_b;
  logic          frame_start;
  modport master (
`ifdef VGA_TESTPATTERN_EN
    input  test_en,
`endif
    input  pix_en, vga_data,
    output h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
  );
  modport slave (
`ifdef VGA_TESTPATTERN_EN
    output test_en,
`endif
    output pix_en, vga_data,
    input  h_addr, v_addr, hsync, vsync, valid, vga_r, vga_g, vga_b, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA timing with sync/blank delayed to match frame-memory latency.
// VGA_TESTPATTERN_EN adds an 8-bar colour pattern selected by test_en.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int HSYNC_POL = 0,
  parameter int VSYNC_POL = 0,
  parameter int RD_LAT    = 1,
  parameter int AW        = 10
) (
  input logic              clock,
  input logic              resetn,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam logic HP = 1'(HSYNC_POL);
  localparam logic VP = 1'(VSYNC_POL);
`ifdef VGA_TESTPATTERN_EN
  localparam int DW = 4 + HW;
`else
  localparam int DW = 4;
`endif
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last, v_last, act0, hs0, vs0, fs0;
  logic [DW-1:0] s0, sd;
  logic [23:0]   pix, rgb;
  assign h_last = h_cnt == HW'(H_TOTAL - 1);
  assign v_last = v_cnt == VW'(V_TOTAL - 1);
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (bus.pix_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end
  assign act0 = 32'(h_cnt) < H_ACTIVE && 32'(v_cnt) < V_ACTIVE;
  assign hs0  = 32'(h_cnt) >= H_ACTIVE + H_FP && 32'(h_cnt) < H_ACTIVE + H_FP + H_SYNC;
  assign vs0  = 32'(v_cnt) >= V_ACTIVE + V_FP && 32'(v_cnt) < V_ACTIVE + V_FP + V_SYNC;
  assign fs0  = h_cnt == '0 && v_cnt == '0;
  assign bus.h_addr = act0 ? AW'(h_cnt) : '0;
  assign bus.v_addr = act0 ? AW'(v_cnt) : '0;
`ifdef VGA_TESTPATTERN_EN
  assign s0 = {h_cnt, act0, hs0, vs0, fs0};
`else
  assign s0 = {act0, hs0, vs0, fs0};
`endif
  // stage flags travel alongside the memory read so RGB meets its own sync/blank
  generate
    if (RD_LAT == 0) begin : g_nodly
      assign sd = s0;
    end else begin : g_dly
      logic [DW-1:0] dl [RD_LAT];
      always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
          for (int i = 0; i < RD_LAT; i++) dl[i] <= '0;
        end else if (bus.pix_en) begin
          dl[0] <= s0;
          for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
        end
      assign sd = dl[RD_LAT-1];
    end
  endgenerate
`ifdef VGA_TESTPATTERN_EN
  logic [HW-1:0] dh;
  logic [2:0]    bar;
  assign dh  = sd[DW-1:4];
  assign bar = 3'(32'(dh) * 8 / H_ACTIVE);
  assign pix = bus.test_en ? {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}} : bus.vga_data;
`else
  assign pix = bus.vga_data;
`endif
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      bus.valid       <= 1'b0;
      bus.hsync       <= ~HP;
      bus.vsync       <= ~VP;
      bus.frame_start <= 1'b0;
      rgb             <= '0;
    end else begin
      bus.frame_start <= bus.pix_en & sd[0];
      if (bus.pix_en) begin
        bus.valid <= sd[3];
        bus.hsync <= sd[2] ? HP : ~HP;
        bus.vsync <= sd[1] ? VP : ~VP;
        rgb       <= sd[3] ? pix : '0;
      end
    end
  assign {bus.vga_r, bus.vga_g, bus.vga_b} = rgb;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of reset, default timing, read latency, pixel strobe and polarity.
module tb_vga_timing_gen;
  logic clock = 1'b0;
  logic resetn = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  always #5 clock = ~clock;
  vga_timing_gen_if b_def ();
  vga_timing_gen_if b_lat ();
  vga_timing_gen_if b_pol ();
  vga_timing_gen u_def (.clock(clock), .resetn(resetn), .bus(b_def));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .RD_LAT(2))
    u_lat (.clock(clock), .resetn(resetn), .bus(b_lat));
  vga_timing_gen #(.H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2), .V_ACTIVE(4), .V_FP(1),
                   .V_SYNC(1), .V_BP(1), .HSYNC_POL(1), .VSYNC_POL(1))
    u_pol (.clock(clock), .resetn(resetn), .bus(b_pol));
  // frame memory for u_lat: data for an address appears two strobes later
  logic [23:0] m0 = '0, m1 = '0;
  always @(posedge clock)
    if (b_lat.pix_en) begin
      m0 <= {b_lat.h_addr[7:0], b_lat.v_addr[7:0], 8'h5A};
      m1 <= m0;
    end
  assign b_lat.vga_data = m1;
  int d_lo1 = 0, d_lo2 = 0, d_hs_first = -1, d_val = 0, d_val_first = -1, d_run = 0, d_max = 0;
  int d_fs = 0, d_fs_at = -1, d_vs_lo = 0;
  int l_k = 0, l_fs = 0, l_val = 0;
  int p_hs = 0, p_vs = 0, p_val = 0, p_vs_first = -1, p_vs_last = -1, p_hs_first = -1;
  int p_fs1 = -1, p_fs2 = -1;
  int e_chg = 0, e_fall1 = -1, e_fall2 = -1, e_lo = 0, e_fs = 0;
  logic e_pe;
  logic [46:0] e_prev, e_snap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_pe(input logic v);
    b_def.pix_en = v;
    b_lat.pix_en = v;
    b_pol.pix_en = v;
  endtask

  initial begin
    set_pe(1'b0);
    b_def.vga_data = 24'h123456;
    b_pol.vga_data = 24'hABCDEF;
`ifdef VGA_TESTPATTERN_EN
    b_def.test_en = 1'b0;
    b_lat.test_en = 1'b0;
    b_pol.test_en = 1'b0;
`endif
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    set_pe(1'b1);
    chk("addr0_h", 32'(b_def.h_addr), 0);
    chk("addr0_v", 32'(b_def.v_addr), 0);
    @(negedge clock);
    chk("addr1_h", 32'(b_def.h_addr), 1);
    chk("addr1_v", 32'(b_def.v_addr), 0);
    repeat (99) @(negedge clock);
    chk("pre_rst_valid", 32'(b_def.valid), 1);
    chk("pre_rst_rgb", {8'h0, b_def.vga_r, b_def.vga_g, b_def.vga_b}, 32'h123456);
    #2 resetn = 1'b0;
    #1;
    chk("rst_valid", 32'(b_def.valid), 0);
    chk("rst_rgb", {8'h0, b_def.vga_r, b_def.vga_g, b_def.vga_b}, 0);
    chk("rst_hsync", 32'(b_def.hsync), 1);
    chk("rst_vsync", 32'(b_def.vsync), 1);
    chk("rst_fs", 32'(b_def.frame_start), 0);
    chk("rst_pol_hsync", 32'(b_pol.hsync), 0);
    chk("rst_pol_vsync", 32'(b_pol.vsync), 0);
    @(negedge clock);
    resetn = 1'b1;
    repeat (700) @(negedge clock);
    chk("pre_rst2_hsync", 32'(b_def.hsync), 0);
    #2 resetn = 1'b0;
    #1;
    chk("rst2_hsync", 32'(b_def.hsync), 1);
    @(negedge clock);
    resetn = 1'b1;
`ifdef VGA_TESTPATTERN_EN
    b_def.test_en = 1'b1;
`endif
    for (int n = 1; n <= 2400; n++) begin
      @(negedge clock);
      if (!b_def.hsync) begin
        if (n <= 800) d_lo1++;
        else if (n <= 1600) d_lo2++;
        if (d_hs_first < 0) d_hs_first = n;
      end
      if (b_def.valid) begin
        d_val++;
        d_run++;
        if (d_val_first < 0) d_val_first = n;
      end else d_run = 0;
      if (d_run > d_max) d_max = d_run;
      if (b_def.frame_start) begin
        d_fs++;
        d_fs_at = n;
      end
      if (!b_def.vsync) d_vs_lo++;
`ifdef VGA_TESTPATTERN_EN
      if (n == 2) chk("tp_px0", {8'h0, b_def.vga_r, b_def.vga_g, b_def.vga_b}, 32'hFFFFFF);
      if (n == 82) chk("tp_px80", {8'h0, b_def.vga_r, b_def.vga_g, b_def.vga_b}, 32'hFFFF00);
      if (n == 641) chk("tp_px639", {8'h0, b_def.vga_r, b_def.vga_g, b_def.vga_b}, 32'h000000);
`endif
      if (b_lat.frame_start) begin
        l_k = 0;
        l_fs++;
        chk("lat_fs_valid", 32'(b_lat.valid), 1);
        chk("lat_fs_rgb", {8'h0, b_lat.vga_r, b_lat.vga_g, b_lat.vga_b}, 32'h00005A);
      end
      if (b_lat.valid) begin
        chk("lat_rgb", {8'h0, b_lat.vga_r, b_lat.vga_g, b_lat.vga_b},
            {8'h0, 8'(l_k % 8), 8'(l_k / 8), 8'h5A});
        l_k++;
        l_val++;
      end
      if (n >= 3 && n <= 100) begin
        if (b_pol.hsync) p_hs++;
        if (b_pol.valid) p_val++;
        if (b_pol.vsync) begin
          p_vs++;
          if (p_vs_first < 0) p_vs_first = n;
          p_vs_last = n;
        end
      end
      if (b_pol.hsync && p_hs_first < 0) p_hs_first = n;
      if (b_pol.frame_start) begin
        if (p_fs1 < 0) p_fs1 = n;
        else if (p_fs2 < 0) p_fs2 = n;
      end
    end
    chk("def_hs_first", d_hs_first, 658);
    chk("def_hs_lo_line0", d_lo1, 96);
    chk("def_hs_lo_line1", d_lo2, 96);
    chk("def_valid_first", d_val_first, 2);
    chk("def_valid_run", d_max, 640);
    chk("def_valid_total", d_val, 1920);
    chk("def_fs_count", d_fs, 1);
    chk("def_fs_at", d_fs_at, 2);
    chk("def_vs_lo", d_vs_lo, 0);
    chk("lat_fs_count", l_fs, 25);
    chk("lat_valid_total", l_val, 796);
    chk("pol_hs_high", p_hs, 14);
    chk("pol_vs_high", p_vs, 14);
    chk("pol_valid", p_val, 32);
    chk("pol_vs_first", p_vs_first, 72);
    chk("pol_vs_last", p_vs_last, 85);
    chk("pol_hs_first", p_hs_first, 12);
    chk("pol_fs1", p_fs1, 2);
    chk("pol_fs2", p_fs2, 100);
`ifdef VGA_TESTPATTERN_EN
    b_def.test_en = 1'b0;
`endif
    @(negedge clock);
    resetn = 1'b0;
    set_pe(1'b0);
    @(negedge clock);
    resetn = 1'b1;
    b_def.pix_en = 1'b1;
    e_pe = 1'b1;
    e_prev = {b_def.hsync, b_def.vsync, b_def.valid, b_def.vga_r, b_def.vga_g, b_def.vga_b,
              b_def.h_addr, b_def.v_addr};
    for (int c = 1; c <= 3200; c++) begin
      @(negedge clock);
      e_snap = {b_def.hsync, b_def.vsync, b_def.valid, b_def.vga_r, b_def.vga_g, b_def.vga_b,
                b_def.h_addr, b_def.v_addr};
      if (!e_pe && e_snap !== e_prev) e_chg++;
      if (e_prev[46] && !e_snap[46]) begin
        if (e_fall1 < 0) e_fall1 = c;
        else if (e_fall2 < 0) e_fall2 = c;
      end
      if (!e_snap[46]) e_lo++;
      if (b_def.frame_start) e_fs++;
      e_prev = e_snap;
      e_pe = ~e_pe;
      b_def.pix_en = e_pe;
    end
    chk("pe2_hold", e_chg, 0);
    chk("pe2_fall1", e_fall1, 1315);
    chk("pe2_period", e_fall2 - e_fall1, 1600);
    chk("pe2_hs_low", e_lo, 384);
    chk("pe2_fs_clocks", e_fs, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA timing and pixel-output generator, the successor to the fixed 640x480 controller between the frame memory and the VGA pins. Porch, sync and active widths, sync polarity and frame-memory read latency are all parameters. A pixel-clock enable lets one system clock drive several pixel rates. Sync and blanking are delayed to match the memory read latency, so RGB always lines up with its own address.

## Interface
Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync asserted level (0 = active-low)
- VSYNC_POL, 0, vsync asserted level
- RD_LAT, 1, frame-memory read latency in pix_en strobes, legal range 0..4
- AW, 10, width of h_addr and v_addr

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; all state advances only when it is high
- vga_data  in  24  {R,G,B} returned by frame memory
- h_addr  out  AW  column being requested
- v_addr  out  AW  row being requested
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- valid  out  1  registered active-video flag (drives BLANK_N)
- vga_r, vga_g, vga_b  out  8 each  registered pixel colour
- frame_start  out  1  one-clock pulse marking the first active pixel of a frame at the output

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; defaults are 800 and 525.
- h_cnt counts 0..H_TOTAL-1, advancing on pix_en. It wraps to 0, and on that wrap v_cnt advances, itself wrapping V_TOTAL-1 to 0.
- Region order inside a line or frame: active, front porch, sync, back porch. Active is h_cnt < H_ACTIVE, so a counter value is its pixel coordinate.
- Stage-0 signals, combinational from the counters:
  - act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hs0 is asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs0 is asserted for v_cnt in the equivalent vertical range
  - fs0 = (h_cnt==0 && v_cnt==0)
- h_addr = act0 ? h_cnt : 0 and v_addr = act0 ? v_cnt : 0, combinational, truncated/zero-extended to AW.
- Delay line: RD_LAT registers carry {act, hs, vs, fs} and advance on pix_en only. With RD_LAT=0 the delay line is empty.
- Output registers load on pix_en from the last delay stage:
  - valid <= act
  - hsync <= hs ? HSYNC_POL : ~HSYNC_POL, and vsync likewise
  - RGB <= act ? vga_data : 0
- frame_start is high for exactly the one clock in which the output registers load with fs=1. It is 0 otherwise.
- While pix_en is low, all registers hold their values.

## Timing
- Output lags address by RD_LAT+1 pix_en strobes. vga_data is sampled RD_LAT strobes after its address was presented.
- Default hsync: 96 strobes asserted, 704 deasserted, 800-strobe period.
- Default vsync: asserted for 2 x 800 strobes, with a 420000-strobe frame period.
- Reset, asynchronous and immediate:
  - counters and delay line go to 0, with all delay stages inactive
  - valid = 0, RGB = 0, frame_start = 0
  - hsync = ~HSYNC_POL and vsync = ~VSYNC_POL (deasserted)
- After resetn rises, the first pix_en presents address (0,0). Reset mid-frame aborts the frame with no partial sync pulse held over.
- Line wrap and frame wrap happen on the same strobe when both counters hit their last value. Both wrap together, and fs0 rises on the next count state.
- pix_en held permanently high gives a one-pixel-per-clock rate.

## Configuration
- VGA_TESTPATTERN_EN defined:
  - adds input test_en (1 bit)
  - when test_en=1, the output RGB load uses an 8-bar colour pattern instead of vga_data
  - bar index = delayed h_cnt * 8 / H_ACTIVE, order white, yellow, cyan, green, magenta, red, blue, black, each component 8'hFF or 8'h00
  - requires h_cnt carried in the delay line
- Undefined: test_en port and pattern logic are absent, and RGB always comes from vga_data.

## Test plan
- Reset values: assert resetn=0 mid-line -> immediately valid=0, RGB=0, hsync=1, vsync=1, frame_start=0; first strobe after release gives h_addr=0, v_addr=0.
- Default timing with pix_en=1:
  - hsync low exactly 96 clocks in every 800
  - vsync low for 1600 clocks in every 420000
  - valid high for 640 consecutive clocks per line on 480 lines
- Latency: RD_LAT=2 with a memory model returning {h_addr[7:0], v_addr[7:0], 8'h5A} after 2 strobes -> every valid pixel's RGB matches its own coordinates; frame_start coincides with output of (0,0).
- Pixel enable: pix_en high every 2nd clock -> hsync period 1600 clocks; outputs stable while pix_en=0.
- Polarity and size: HSYNC_POL=1, VSYNC_POL=1, H_ACTIVE=8, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1 -> hsync high 2 of 14 strobes, vsync high 14 of 98 strobes, both counters wrap on the same strobe.
- With VGA_TESTPATTERN_EN, test_en=1, defaults: pixel 0 = FFFFFF, pixel 80 = FFFF00, pixel 639 = 000000, irrespective of vga_data.
